// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment debug display.
// Active-low segment patterns (bit0=a .. bit6=g), FSM states, helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Channel-select width; a single channel still gets a 1-bit port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Nibbles 10..15 never leave the converter; show them blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD, one bit per clock.
// valid is high for the single LOAD cycle; ovf flags a lost top carry.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VAL_W  = 16,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAL_W-1:0]      value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  valid,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    state_e             state_q, state_d;
    logic [VAL_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    // Add 3 to every nibble >= 5 ahead of the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: snapshot on start, VAL_W shifts, one LOAD cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = value;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(VAL_W - 1);
                    ovf_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, shreg_d} = {bcd_adj[BCD_W-2:0], shreg_q, 1'b0};
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                if (cnt_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bcd   = bcd_q;
    assign ovf   = ovf_q;
    assign valid = (state_q == ST_LOAD);
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: rtl/seg7_multi_display.sv
// seg7_multi_display: time-multiplexed multi-channel 7-segment display.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter  int NCH      = 2,
    parameter  int VAL_W    = 16,
    parameter  int DIGITS   = 6,
    parameter  int TICK_DIV = 50_000_000,
    localparam int SEL_W    = sel_width(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*VAL_W-1:0]  ch_val,
    input  logic [SEL_W-1:0]      ch_sel,
    input  logic                  upd_req,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]      tick_cnt;
    logic                  tick;
    logic [VAL_W-1:0]      sel_val;
    logic [4*DIGITS-1:0]   conv_bcd;
    logic                  conv_ovf;
    logic                  conv_valid;
    logic [7*DIGITS-1:0]   seg_d;
    logic [3:0]            nib;
    logic                  lead;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Free-running refresh divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Channel mux; out-of-range selects fall back to channel 0.
    always_comb begin
        sel_val = ch_val[0 +: VAL_W];
        for (int i = 1; i < NCH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                sel_val = ch_val[i*VAL_W +: VAL_W];
            end
        end
    end

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (tick | upd_req),
        .value (sel_val),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf),
        .valid (conv_valid),
        .busy  (busy)
    );

    // Decode nibbles, scanning from the top to find leading zeros.
    always_comb begin
        seg_d = '0;
        nib   = '0;
        lead  = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nib = conv_bcd[4*d +: 4];
            if (LZ_BLANK && lead && d != 0 && nib == 4'd0) begin
                seg_d[7*d +: 7] = SEG_BLANK;
            end else begin
                seg_d[7*d +: 7] = seg_decode(nib);
                lead = 1'b0;
            end
        end
        if (conv_ovf) begin
            seg_d = {DIGITS{SEG_DASH}};
        end
    end

    // Output registers; seg holds between conversions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg  <= {DIGITS{SEG_BLANK}};
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= conv_valid;
            if (conv_valid) begin
                seg <= seg_d;
                ovf <= conv_ovf;
            end
        end
    end

endmodule

// File: tb/tb_seg7_multi_display.sv
// tb_seg7_multi_display: scoreboard bench for two display instances.
// A: NCH=2, DIGITS=6; B: NCH=3, DIGITS=4 (overflow and select fallback).
`timescale 1ns/1ps
module tb_seg7_multi_display;

    localparam int VAL_W = 16;
    localparam int TICK  = 32;
    localparam int DA    = 6;
    localparam int DB    = 4;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   ch_val = '0;
    logic [1:0]    sel = '0;
    logic          upd_req = 1'b0;
    logic [41:0]   seg_a;
    logic [27:0]   seg_b;
    logic          busy_a, done_a, ovf_a;
    logic          busy_b, done_b, ovf_b;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [41:0] seg;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   rem_a = 0;
    int   rem_b = 0;
    int   mcnt = 0;
    int   edge_n = 0;

    seg7_multi_display #(
        .NCH(2), .VAL_W(VAL_W), .DIGITS(DA), .TICK_DIV(TICK)
    ) u_a (
        .clk(clk), .rst(rst), .ch_val(ch_val), .ch_sel(sel[0]),
        .upd_req(upd_req), .seg(seg_a), .busy(busy_a),
        .done(done_a), .ovf(ovf_a)
    );

    seg7_multi_display #(
        .NCH(3), .VAL_W(VAL_W), .DIGITS(DB), .TICK_DIV(TICK)
    ) u_b (
        .clk(clk), .rst(rst), .ch_val({16'd5555, ch_val}), .ch_sel(sel),
        .upd_req(upd_req), .seg(seg_b), .busy(busy_b),
        .done(done_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int n);
        case (n)
            0: return P0;
            1: return P1;
            2: return P2;
            3: return P3;
            4: return P4;
            5: return P5;
            6: return P6;
            7: return P7;
            8: return P8;
            default: return P9;
        endcase
    endfunction

    function automatic int lim_of(input int d);
        int l = 1;
        for (int k = 0; k < d; k++) l = l * 10;
        return l;
    endfunction

    function automatic logic [41:0] exp_seg(input int v, input int d);
        logic [41:0] r;
        int x;
        int p;
        r = '0;
        if (v >= lim_of(d)) begin
            for (int k = 0; k < d; k++) r[7*k +: 7] = DS;
            return r;
        end
        x = v;
        p = 1;
        for (int k = 0; k < d; k++) begin
            r[7*k +: 7] = pat(x % 10);
`ifdef SEG7_LZ_BLANK_EN
            if (k > 0 && v < p) r[7*k +: 7] = BL;
`endif
            x = x / 10;
            p = p * 10;
        end
        return r;
    endfunction

    // Reference model: tick divider, busy window, snapshot at accept.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            qa.delete();
            qb.delete();
            rem_a = 0;
            rem_b = 0;
            mcnt  = 0;
        end else begin
            bit     tk;
            int     v;
            int     idx;
            exp_t   e;
            logic [47:0] cvb;
            edge_n++;
            tk   = (mcnt == TICK - 1);
            mcnt = tk ? 0 : mcnt + 1;
            if (rem_a > 0) begin
                rem_a--;
            end else if (tk || upd_req) begin
                idx = int'(sel[0]);
                v = int'(ch_val[idx*16 +: 16]);
                e.seg = exp_seg(v, DA);
                e.ovf = (v >= lim_of(DA));
                e.due = edge_n + VAL_W + 1;
                qa.push_back(e);
                rem_a = VAL_W + 1;
            end
            if (rem_b > 0) begin
                rem_b--;
            end else if (tk || upd_req) begin
                cvb = {16'd5555, ch_val};
                idx = (sel < 2'd3) ? int'(sel) : 0;
                v = int'(cvb[idx*16 +: 16]);
                e.seg = exp_seg(v, DB);
                e.ovf = (v >= lim_of(DB));
                e.due = edge_n + VAL_W + 1;
                qb.push_back(e);
                rem_b = VAL_W + 1;
            end
        end
    end

    // Monitor: compare busy every cycle, pop and compare on each done.
    always @(negedge clk) begin
        if (rst) begin
            exp_t e;
            chk("busy_a", 64'(busy_a), 64'(rem_a > 0));
            chk("busy_b", 64'(busy_b), 64'(rem_b > 0));
            if (done_a) begin
                if (qa.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_a: unexpected pulse at edge %0d", edge_n);
                end else begin
                    e = qa.pop_front();
                    chk("seg_a", 64'(seg_a), 64'(e.seg));
                    chk("ovf_a", 64'(ovf_a), 64'(e.ovf));
                    chk("lat_a", 64'(edge_n), 64'(e.due));
                end
            end
            if (done_b) begin
                if (qb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_b: unexpected pulse at edge %0d", edge_n);
                end else begin
                    e = qb.pop_front();
                    chk("seg_b", 64'(seg_b), 64'(e.seg));
                    chk("ovf_b", 64'(ovf_b), 64'(e.ovf));
                    chk("lat_b", 64'(edge_n), 64'(e.due));
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy_a || busy_b) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL wait_idle: busy stuck got 1 expected 0");
        end
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done_a && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL %s: no done got 0 expected 1", nm);
        end
    endtask

    task automatic request();
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_seg_a", 64'(seg_a), 64'({6{BL}}));
        chk("rst_seg_b", 64'(seg_b), 64'({4{BL}}));
        chk("rst_busy", 64'({busy_a, busy_b}), 64'(0));
        chk("rst_done", 64'({done_a, done_b}), 64'(0));
        chk("rst_ovf", 64'({ovf_a, ovf_b}), 64'(0));
        rst = 1'b1;

        // 1234 on channel 0 via immediate request
        ch_val = {16'hFFFF, 16'd1234};
        sel = 2'd0;
        @(negedge clk);
        request();
        wait_done("d1234");
`ifdef SEG7_LZ_BLANK_EN
        chk("a_1234", 64'(seg_a), 64'({BL, BL, P1, P2, P3, P4}));
`else
        chk("a_1234", 64'(seg_a), 64'({P0, P0, P1, P2, P3, P4}));
`endif
        chk("b_1234", 64'(seg_b), 64'({P1, P2, P3, P4}));

        // 65535 on channel 1 via refresh tick only
        wait_idle();
        sel = 2'd1;
        wait_done("dtick");
`ifdef SEG7_LZ_BLANK_EN
        chk("a_65535", 64'(seg_a), 64'({BL, P6, P5, P5, P3, P5}));
`else
        chk("a_65535", 64'(seg_a), 64'({P0, P6, P5, P5, P3, P5}));
`endif
        chk("a_65535_ovf", 64'(ovf_a), 64'(0));
        chk("b_65535", 64'(seg_b), 64'({DS, DS, DS, DS}));
        chk("b_65535_ovf", 64'(ovf_b), 64'(1));

        // 12345 overflows four digits
        wait_idle();
        sel = 2'd0;
        ch_val[15:0] = 16'd12345;
        request();
        wait_done("d12345");
        chk("b_12345", 64'(seg_b), 64'({DS, DS, DS, DS}));
        chk("b_12345_ovf", 64'(ovf_b), 64'(1));
        chk("a_12345", 64'(seg_a), 64'({P0, P1, P2, P3, P4, P5}));

        // 42 clears overflow
        wait_idle();
        ch_val[15:0] = 16'd42;
        request();
        wait_done("d42");
`ifdef SEG7_LZ_BLANK_EN
        chk("b_42", 64'(seg_b), 64'({BL, BL, P4, P2}));
`else
        chk("b_42", 64'(seg_b), 64'({P0, P0, P4, P2}));
`endif
        chk("b_42_ovf", 64'(ovf_b), 64'(0));

        // Requests every cycle and value change during conversion
        wait_idle();
        ch_val[15:0] = 16'd999;
        upd_req = 1'b1;
        @(negedge clk);
        ch_val[15:0] = 16'd7;
        repeat (10) @(negedge clk);
        upd_req = 1'b0;
        wait_done("d999");
`ifdef SEG7_LZ_BLANK_EN
        chk("a_999", 64'(seg_a), 64'({BL, BL, BL, P9, P9, P9}));
`else
        chk("a_999", 64'(seg_a), 64'({P0, P0, P0, P9, P9, P9}));
`endif

        // Out-of-range select on B falls back to channel 0 = 0
        wait_idle();
        ch_val[15:0] = 16'd0;
        sel = 2'd3;
        request();
        wait_done("dsel3");
`ifdef SEG7_LZ_BLANK_EN
        chk("b_zero", 64'(seg_b), 64'({BL, BL, BL, P0}));
`else
        chk("b_zero", 64'(seg_b), 64'({P0, P0, P0, P0}));
`endif
        chk("a_sel3", 64'(seg_a), 64'(exp_seg(65535, DA)));

        // Reset in the middle of a conversion
        wait_idle();
        request();
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_seg_a", 64'(seg_a), 64'({6{BL}}));
        chk("mid_rst_seg_b", 64'(seg_b), 64'({4{BL}}));
        chk("mid_rst_busy", 64'({busy_a, busy_b}), 64'(0));
        chk("mid_rst_done", 64'({done_a, done_b}), 64'(0));
        chk("mid_rst_ovf", 64'({ovf_a, ovf_b}), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("qa_empty", 64'(qa.size()), 64'(0));
        chk("qb_empty", 64'(qb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
